// File: rtl/mem_access_stage.sv
// mem_access_stage: RV64 MEM stage with a LAT-cycle byte-addressed little-endian data memory.
// Define MEM_MISALIGN_TRAP_EN to suppress misaligned accesses and flag them on misalign.
module mem_access_stage #(
  parameter int DEPTH_BYTES = 1024,
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  in_rd,
  input  logic [63:0] in_alu,
  input  logic [63:0] in_wdata,
  input  logic [2:0]  in_funct3,
  input  logic        in_memread,
  input  logic        in_memwrite,
  input  logic        in_regwrite,
  input  logic        in_memtoreg,
  output logic        stall,
  output logic [4:0]  out_rd,
  output logic [63:0] out_alu,
  output logic [63:0] out_rdata,
  output logic        out_regwrite,
  output logic        out_memtoreg,
  output logic        misalign
);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (LAT > 2) ? $clog2(LAT) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0] rd_q;
  logic [63:0] alu_q, wdata_q, rdata_q, rdata_d, raw, a_wdata;
  logic [2:0] f3_q, a_f3, lowmask;
  logic we_q, rw_q, mtr_q, mis_q;
  logic memop, fire, a_we, mis;
  logic [1:0] sz;
  logic [AW-1:0] a_addr, addr;
  logic [7:0] mem [DEPTH_BYTES];
  assign memop = in_memread | in_memwrite;
  // In IDLE the access may fire this edge (LAT=1), before the capture registers are loaded
  assign a_addr = (state_q == IDLE) ? in_alu[AW-1:0] : alu_q[AW-1:0];
  assign a_wdata = (state_q == IDLE) ? in_wdata : wdata_q;
  assign a_f3 = (state_q == IDLE) ? in_funct3 : f3_q;
  assign a_we = (state_q == IDLE) ? in_memwrite : we_q;
  assign fire = (state_q == IDLE && memop && LAT == 1) || (state_q == BUSY && cnt_q == '0);
  assign sz = (!a_we && a_f3 == 3'b111) ? 2'd3 : a_f3[1:0];
  assign lowmask = {sz == 2'd3, sz[1], |sz};
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = |(a_addr[2:0] & lowmask);
  assign addr = a_addr;
`else
  assign mis = 1'b0;
  assign addr = a_addr & ~AW'(lowmask);
`endif
  always_comb
    for (int k = 0; k < 8; k++) raw[8*k +: 8] = mem[addr + AW'(k)];
  always_comb
    rdata_d = (a_we | mis) ? '0 :
              (sz == 2'd0) ? (a_f3[2] ? {56'd0, raw[7:0]}  : {{56{raw[7]}}, raw[7:0]}) :
              (sz == 2'd1) ? (a_f3[2] ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]}) :
              (sz == 2'd2) ? (a_f3[2] ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]}) : raw;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (memop) begin
        state_d = (LAT == 1) ? DONE : BUSY;
        cnt_d = CW'(LAT > 1 ? LAT - 2 : 0);
      end
      BUSY: begin
        state_d = (cnt_q == '0) ? DONE : BUSY;
        cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rd_q <= '0;
      alu_q <= '0;
      wdata_q <= '0;
      f3_q <= '0;
      we_q <= 1'b0;
      rw_q <= 1'b0;
      mtr_q <= 1'b0;
      rdata_q <= '0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (state_q == IDLE && memop) begin
        rd_q <= in_rd;
        alu_q <= in_alu;
        wdata_q <= in_wdata;
        f3_q <= in_funct3;
        we_q <= in_memwrite;
        rw_q <= in_regwrite;
        mtr_q <= in_memtoreg;
      end
      if (fire) begin
        rdata_q <= rdata_d;
        mis_q <= mis;
      end
    end
  // Contents survive reset; a reset at the write edge cancels the store
  always_ff @(posedge clk)
    if (fire && a_we && !mis && !reset)
      for (int k = 0; k < 8; k++)
        if (k <= int'(lowmask)) mem[addr + AW'(k)] <= a_wdata[8*k +: 8];
  always_comb begin
    stall = 1'b0;
    out_rd = '0;
    out_alu = '0;
    out_rdata = '0;
    out_regwrite = 1'b0;
    out_memtoreg = 1'b0;
    misalign = 1'b0;
    if (!reset) begin
      if (state_q == DONE) begin
        out_rd = rd_q;
        out_alu = alu_q;
        out_rdata = rdata_q;
        out_regwrite = rw_q & ~we_q & ~mis_q;
        out_memtoreg = mtr_q;
        misalign = mis_q;
      end else if (state_q == BUSY || memop) begin
        stall = 1'b1;
      end else begin
        out_rd = in_rd;
        out_alu = in_alu;
        out_regwrite = in_regwrite;
        out_memtoreg = in_memtoreg;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed table, reset-abort and LAT=1 sequences, then random ops
// checked against a byte-array memory model.
module tb_mem_access_stage;
  localparam int LAT = 2;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [4:0] in_rd;
  logic [63:0] in_alu, in_wdata;
  logic [2:0] in_funct3;
  logic in_memread, in_memwrite, in_regwrite, in_memtoreg, re1, we1;
  logic stall, out_regwrite, out_memtoreg, misalign;
  logic [4:0] out_rd;
  logic [63:0] out_alu, out_rdata;
  logic stall1, o1_regwrite, o1_memtoreg, o1_misalign;
  logic [4:0] o1_rd;
  logic [63:0] o1_alu, o1_rdata;
  int checks = 0, fails = 0;
  logic [7:0] mem_m [1024];

  mem_access_stage #(.DEPTH_BYTES(1024), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .in_rd(in_rd), .in_alu(in_alu), .in_wdata(in_wdata),
    .in_funct3(in_funct3), .in_memread(in_memread), .in_memwrite(in_memwrite),
    .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .stall(stall), .out_rd(out_rd),
    .out_alu(out_alu), .out_rdata(out_rdata), .out_regwrite(out_regwrite),
    .out_memtoreg(out_memtoreg), .misalign(misalign));

  mem_access_stage #(.DEPTH_BYTES(1024), .LAT(1)) dut1 (
    .clk(clk), .reset(reset), .in_rd(in_rd), .in_alu(in_alu), .in_wdata(in_wdata),
    .in_funct3(in_funct3), .in_memread(re1), .in_memwrite(we1),
    .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .stall(stall1), .out_rd(o1_rd),
    .out_alu(o1_alu), .out_rdata(o1_rdata), .out_regwrite(o1_regwrite),
    .out_memtoreg(o1_memtoreg), .misalign(o1_misalign));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model(input logic we, input logic [2:0] f3, input logic [63:0] a64, input logic [63:0] wd,
                       input logic rw, output logic [63:0] rdata, output logic orw, output logic omis);
    int n, a;
    logic [63:0] raw;
    n = we ? (1 << f3[1:0]) : (f3 == 3'b111 ? 8 : (1 << f3[1:0]));
    a = int'(a64 % 64'd1024);
    omis = TRAP && (a % n != 0);
    if (!TRAP) a -= a % n;
    raw = '0;
    if (!omis)
      for (int i = 0; i < n; i++)
        if (we) mem_m[(a + i) % 1024] = wd[8*i +: 8];
        else raw |= 64'(mem_m[(a + i) % 1024]) << (8 * i);
    if (!we && f3 < 3'd3 && raw[8*n-1]) raw |= ~((64'd1 << (8 * n)) - 64'd1);
    rdata = (we || omis) ? '0 : raw;
    orw = rw && !we && !omis;
  endtask

  task automatic nop();
    in_memread = 1'b0;
    in_memwrite = 1'b0;
  endtask

  task automatic op(input logic re, input logic we, input logic [2:0] f3, input logic [63:0] a64,
                    input logic [63:0] wd, input logic [4:0] rd, input logic rw, input logic mtr,
                    output logic [63:0] g_rdata, output logic g_rw, output logic g_mis);
    logic [63:0] e_rdata;
    logic e_rw, e_mis, mop;
    int st;
    mop = re | we;
    in_rd = rd; in_alu = a64; in_wdata = wd; in_funct3 = f3;
    in_memread = re; in_memwrite = we; in_regwrite = rw; in_memtoreg = mtr;
    e_rdata = '0; e_rw = rw; e_mis = 1'b0;
    if (mop) model(we, f3, a64, wd, rw, e_rdata, e_rw, e_mis);
    st = 0;
    @(negedge clk);
    while (stall && st < 20) begin
      chk("bubble_regwrite", 64'(out_regwrite), 64'd0);
      chk("bubble_rd", 64'(out_rd), 64'd0);
      st++;
      @(negedge clk);
    end
    chk("stall_cycles", 64'(st), mop ? 64'(LAT) : 64'd0);
    chk("out_rd", 64'(out_rd), 64'(rd));
    chk("out_alu", out_alu, a64);
    chk("out_rdata", out_rdata, e_rdata);
    chk("out_regwrite", 64'(out_regwrite), 64'(e_rw));
    chk("out_memtoreg", 64'(out_memtoreg), 64'(mtr));
    chk("misalign", 64'(misalign), 64'(e_mis));
    g_rdata = out_rdata; g_rw = out_regwrite; g_mis = misalign;
    @(posedge clk);
    #1 nop();
  endtask

  task automatic op1(input logic re, input logic we, input logic [63:0] a, input logic [63:0] wd,
                     output int st, output logic [63:0] rdata);
    in_funct3 = 3'b011; in_alu = a; in_wdata = wd; re1 = re; we1 = we;
    st = 0;
    @(negedge clk);
    while (stall1 && st < 20) begin
      st++;
      @(negedge clk);
    end
    rdata = o1_rdata;
    @(posedge clk);
    #1 begin re1 = 1'b0; we1 = 1'b0; end
  endtask

  typedef struct {
    logic re, we;
    logic [2:0] f3;
    logic [63:0] addr, wd, exp;
    logic erw, emis;
  } vec_t;
  vec_t tv[17];

  initial begin
    logic [63:0] g_rdata;
    logic g_rw, g_mis;
    int st;
    tv[0]  = '{1'b0, 1'b1, 3'b011, 64'h10,  64'h1122334455667788, 64'h0, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 3'b011, 64'h10,  64'h0, 64'h1122334455667788, 1'b1, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 3'b000, 64'h17,  64'h0, 64'h11, 1'b1, 1'b0};
    tv[3]  = '{1'b0, 1'b1, 3'b000, 64'h10,  64'h80, 64'h0, 1'b0, 1'b0};
    tv[4]  = '{1'b1, 1'b0, 3'b000, 64'h10,  64'h0, 64'hFFFFFFFFFFFFFF80, 1'b1, 1'b0};
    tv[5]  = '{1'b1, 1'b0, 3'b100, 64'h10,  64'h0, 64'h80, 1'b1, 1'b0};
    tv[6]  = '{1'b1, 1'b0, 3'b001, 64'h16,  64'h0, 64'h1122, 1'b1, 1'b0};
    tv[7]  = '{1'b1, 1'b0, 3'b111, 64'h10,  64'h0, 64'h1122334455667780, 1'b1, 1'b0};
    tv[8]  = '{1'b0, 1'b1, 3'b010, 64'h20,  64'h12345678, 64'h0, 1'b0, 1'b0};
    if (TRAP) tv[9] = '{1'b1, 1'b0, 3'b010, 64'h22, 64'h0, 64'h0, 1'b0, 1'b1};
    else      tv[9] = '{1'b1, 1'b0, 3'b010, 64'h22, 64'h0, 64'h12345678, 1'b1, 1'b0};
    tv[10] = '{1'b0, 1'b1, 3'b010, 64'h30,  64'hF0000000, 64'h0, 1'b0, 1'b0};
    tv[11] = '{1'b1, 1'b0, 3'b010, 64'h30,  64'h0, 64'hFFFFFFFFF0000000, 1'b1, 1'b0};
    tv[12] = '{1'b1, 1'b0, 3'b110, 64'h30,  64'h0, 64'hF0000000, 1'b1, 1'b0};
    tv[13] = '{1'b1, 1'b1, 3'b001, 64'h40,  64'hABCD, 64'h0, 1'b0, 1'b0};
    tv[14] = '{1'b1, 1'b0, 3'b101, 64'h40,  64'h0, 64'hABCD, 1'b1, 1'b0};
    tv[15] = '{1'b0, 1'b1, 3'b001, 64'h3FE, 64'hABCD, 64'h0, 1'b0, 1'b0};
    tv[16] = '{1'b1, 1'b0, 3'b101, 64'h3FE, 64'h0, 64'hABCD, 1'b1, 1'b0};
    for (int i = 0; i < 1024; i++) mem_m[i] = 8'h0;
    in_rd = 5'd5; in_alu = 64'h2A; in_wdata = '0; in_funct3 = '0;
    in_regwrite = 1'b1; in_memtoreg = 1'b0; re1 = 1'b0; we1 = 1'b0;
    nop();
    #12;
    chk("reset_out_rd", 64'(out_rd), 64'd0);
    chk("reset_out_alu", out_alu, 64'd0);
    chk("reset_out_regwrite", 64'(out_regwrite), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    op(1'b0, 1'b0, 3'b000, 64'h2A, 64'h0, 5'd5, 1'b1, 1'b0, g_rdata, g_rw, g_mis);
    for (int a = 0; a < 128; a += 8)
      op(1'b0, 1'b1, 3'b011, 64'(a), {$urandom, $urandom}, 5'd0, 1'b0, 1'b0, g_rdata, g_rw, g_mis);
    op(1'b0, 1'b1, 3'b011, 64'h3F8, {$urandom, $urandom}, 5'd0, 1'b0, 1'b0, g_rdata, g_rw, g_mis);
    for (int i = 0; i < 17; i++) begin
      op(tv[i].re, tv[i].we, tv[i].f3, tv[i].addr, tv[i].wd, 5'(i), 1'b1, tv[i].re, g_rdata, g_rw, g_mis);
      chk($sformatf("vec%0d_rdata", i), g_rdata, tv[i].exp);
      chk($sformatf("vec%0d_regwrite", i), 64'(g_rw), 64'(tv[i].erw));
      chk($sformatf("vec%0d_misalign", i), 64'(g_mis), 64'(tv[i].emis));
    end
    in_rd = 5'd9; in_alu = 64'h20; in_wdata = 64'hDEADBEEF; in_funct3 = 3'b010; in_memwrite = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy_stall", 64'(stall), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_stall", 64'(stall), 64'd0);
    chk("abort_out_alu", out_alu, 64'd0);
    chk("abort_out_rd", 64'(out_rd), 64'd0);
    nop();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    op(1'b1, 1'b0, 3'b010, 64'h20, 64'h0, 5'd3, 1'b1, 1'b1, g_rdata, g_rw, g_mis);
    chk("abort_lw_prior", g_rdata, 64'h12345678);
    op1(1'b0, 1'b1, 64'h18, 64'hCAFEF00D12345678, st, g_rdata);
    chk("lat1_sd_stall", 64'(st), 64'd1);
    op1(1'b1, 1'b0, 64'h18, 64'h0, st, g_rdata);
    chk("lat1_ld_stall", 64'(st), 64'd1);
    chk("lat1_ld_rdata", g_rdata, 64'hCAFEF00D12345678);
    for (int i = 0; i < 300; i++) begin
      int kind, a;
      logic [63:0] a64;
      kind = int'($urandom_range(0, 3));
      a = $urandom_range(0, 1) ? int'($urandom_range(0, 127)) : int'($urandom_range(1016, 1023));
      a64 = {32'($urandom), 22'($urandom), 10'(a)};
      op(kind == 1 || kind == 3, kind >= 2, 3'($urandom_range(0, 7)), a64, {$urandom, $urandom},
         5'($urandom), 1'($urandom), 1'($urandom), g_rdata, g_rw, g_mis);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
